// File: rtl/core_pkg.sv
// Shared core definitions: memory size codes (also used by ALU control),
// LSU state encoding and the size-code decode helpers.
package core_pkg;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_B    = 3'b001;
  localparam logic [2:0] MEM_H    = 3'b010;
  localparam logic [2:0] MEM_W    = 3'b011;
  localparam logic [2:0] MEM_BU   = 3'b101;
  localparam logic [2:0] MEM_HU   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  function automatic logic mem_legal(input logic [2:0] m);
    return (m == MEM_B) || (m == MEM_H) || (m == MEM_W) ||
           (m == MEM_BU) || (m == MEM_HU);
  endfunction

  function automatic logic mem_misaligned(input logic [2:0] m, input logic [1:0] off);
    logic half;
    half = (m == MEM_H) || (m == MEM_HU);
    return (half && off[0]) || ((m == MEM_W) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] mem_be(input logic [2:0] m, input logic [1:0] off);
    logic [3:0] be;
    case (m)
      MEM_B, MEM_BU: be = 4'b0001 << off;
      MEM_H, MEM_HU: be = 4'b0011 << off;
      MEM_W:         be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes; the byte enables pick the live one.
  function automatic logic [31:0] mem_store_data(input logic [2:0] m, input logic [31:0] d);
    logic [31:0] sd;
    case (m)
      MEM_B, MEM_BU: sd = {4{d[7:0]}};
      MEM_H, MEM_HU: sd = {2{d[15:0]}};
      default:       sd = d;
    endcase
    return sd;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select plus sign/zero extension for a 32-bit
// memory word; reusable by any block returning raw words.
module lsu_load_align
  import core_pkg::*;
(
  input  logic [2:0]  mem,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (mem)
      MEM_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  data = {24'h0, shifted[7:0]};
      MEM_HU:  data = {16'h0, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access unit: one data-memory transaction per start pulse,
// with alignment/legality checks, byte enables, store lane replication and timeout.
module lsu_mem_access
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Memory handshake: dmem_req is held high with stable addr/be/we/wdata until
  // the memory answers with dmem_ack in a cycle where dmem_req is high; that
  // cycle completes the transfer. Ack in any other cycle is ignored.

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        mem_q, mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_data;

  lsu_load_align u_align (
    .mem  (mem_q),
    .lane (addr_q[1:0]),
    .word (dmem_rdata),
    .data (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    mem_d      = mem_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          is_store_d = is_store;
          mem_d      = mem;
          addr_d     = addr;
          wdata_d    = wdata;
          if (!mem_legal(mem) || mem_misaligned(mem, addr[1:0])) state_d = ST_ERR;
          else                                                   state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack takes priority over the timeout expiring in the same cycle.
        if (dmem_ack) begin
          state_d = ST_DONE;
          if (!is_store_q) rdata_d = load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      mem_q      <= MEM_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      mem_q      <= mem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    err        = (state_q == ST_ERR);
    rdata      = rdata_q;
    dmem_req   = (state_q == ST_REQ);
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_addr  = '0;
    dmem_wdata = 32'h0;
    if (dmem_req) begin
      dmem_we    = is_store_q;
      dmem_be    = mem_be(mem_q, addr_q[1:0]);
      dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      dmem_wdata = mem_store_data(mem_q, wdata_q);
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: vector table plus hand-written
// sequences for timeout, ack-at-limit, start-while-busy and mid-transaction reset.
module tb_lsu_mem_access;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  mem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int checks = 0;
  int errors = 0;

  lsu_mem_access #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .mem        (mem),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          dly;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic st, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; is_store = st; mem = m; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    pulse_start(v.st, v.mem, v.addr, v.wdata);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    if (v.e_err) begin
      chk($sformatf("v%0d_err", idx), 32'(err), 32'd1);
      chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_err_end", idx), 32'(err), 32'd0);
      chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d_rdata", idx), rdata, v.e_rdata);
    end else begin
      for (int k = 0; k < v.dly; k++) begin
        chk($sformatf("v%0d_req_w%0d", idx, k), 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'd1);
      chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.st));
      chk($sformatf("v%0d_be", idx), 32'(dmem_be), 32'(v.e_be));
      chk($sformatf("v%0d_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.e_wdata);
      dmem_ack = 1'b1; dmem_rdata = v.mrd;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d_noerr", idx), 32'(err), 32'd0);
      chk($sformatf("v%0d_req_off", idx), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d_rdata", idx), rdata, v.e_rdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_end", idx), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t follow;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mem = 3'b000;
    addr = 32'h0; wdata = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;

    //           st    mem     addr          wdata         mem rdata     dly err be       exp wdata     exp rdata
    vecs[0]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b101, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b1, 3'b010, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
    vecs[4]  = '{1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_0103, 32'h5555_5555, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[7]  = '{1'b0, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[8]  = '{1'b1, 3'b111, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[10] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0301, 32'hAABB_CC5A, 32'h0,        0, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_F00D};
    vecs[12] = '{1'b1, 3'b011, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        3, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_F00D};
    vecs[13] = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h007F_0000, 0, 1'b0, 4'b0100, 32'h0,        32'h0000_007F};
    // ack lands in the 15th REQ cycle, exactly when the timeout would fire
    vecs[14] = '{1'b0, 3'b011, 32'h0000_0500, 32'h0,        32'h1357_9BDF, 14, 1'b0, 4'b1111, 32'h0,       32'h1357_9BDF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // timeout: no ack for 15 REQ cycles
    pulse_start(1'b0, 3'b011, 32'h0000_0600, 32'h0);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("to_req_%0d", k), 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_req_off", 32'(dmem_req), 32'd0);
    chk("to_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("to_err_end", 32'(err), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_rdata", rdata, 32'h1357_9BDF);
    follow = '{1'b0, 3'b011, 32'h0000_0604, 32'h0, 32'h2468_ACE0, 0, 1'b0, 4'b1111, 32'h0, 32'h2468_ACE0};
    run_vec(follow, 100);

    // start while busy is ignored
    pulse_start(1'b0, 3'b011, 32'h0000_0800, 32'h0);
    pulse_start(1'b1, 3'b001, 32'h0000_0901, 32'h0000_00EE);
    chk("ign_addr", dmem_addr, 32'h0000_0800);
    chk("ign_we", 32'(dmem_we), 32'd0);
    chk("ign_be", 32'(dmem_be), 32'hF);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_rdata", rdata, 32'h0BAD_F00D);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ign_noreq_%0d", k), 32'(dmem_req), 32'd0);
      chk($sformatf("ign_nobusy_%0d", k), 32'(busy), 32'd0);
    end

    // reset in REQ; the ack that would have arrived later must have no effect
    pulse_start(1'b0, 3'b011, 32'h0000_0A00, 32'h0);
    @(posedge clk); #1;
    chk("rr_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_req", 32'(dmem_req), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_nodone_%0d", k), 32'(done), 32'd0);
      chk($sformatf("rr_noerr_%0d", k), 32'(err), 32'd0);
      chk($sformatf("rr_idle_%0d", k), 32'(busy), 32'd0);
    end
    chk("rr_rdata_end", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access unit that consumes the 3-bit `mem` size code produced by ALU control, plus the ALU-computed effective address.
- Runs one data-memory transaction per request over a req/ack handshake.
- Generates byte enables and lane-shifted store data; returns sign- or zero-extended load data.
- Sits between the EX stage and the data memory port; stalls the core via `busy`.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT, 15, maximum cycles to wait for `dmem_ack` before aborting with `err`

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- mem  in  3  size code: 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned; 000 = no access
- addr  in  ADDR_W  effective byte address
- wdata  in  32  store data, right-aligned
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: misaligned access, illegal code, or timeout
- rdata  out  32  extended load result; held until the next load completes
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_be  out  4  byte enables
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  memory read word
- dmem_ack  in  1  memory completion, valid while dmem_req is high

Behaviour:
Reset:
- All outputs 0; state IDLE; timeout counter 0.
- Reset mid-transaction drops `dmem_req` immediately; no `done` or `err` follows.

FSM states: IDLE, REQ, DONE, ERR.

IDLE:
- On `start`, latch is_store, mem, addr, wdata.
- Illegal code (000, 100, 111) -> ERR.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
- Otherwise -> REQ.
- `busy` rises the cycle after `start`.

REQ:
- `dmem_req` = 1. `dmem_addr`, `dmem_be`, `dmem_we`, `dmem_wdata` are driven from the latched values and held stable until ack.
- On `dmem_ack` -> DONE.
- Loads: capture `dmem_rdata` on the ack cycle.
- Counter increments each REQ cycle without ack; reaching TIMEOUT -> ERR with `dmem_req` dropped.

DONE:
- `done` = 1 for one cycle; `rdata` updated for loads; -> IDLE.

ERR:
- `err` = 1 for one cycle; `rdata` unchanged; -> IDLE.

Byte enables:
- byte: 0001 << addr[1:0]
- half: 0011 << addr[1:0] (addr[1:0] is 0 or 2)
- word: 1111

Store data:
- byte: replicated {4{wdata[7:0]}}
- half: replicated {2{wdata[15:0]}}
- word: passthrough
- The memory uses `dmem_be` to select lanes.

Load extension:
- Select the lane `dmem_rdata >> (8*addr[1:0])`.
- Codes 001 and 010 sign-extend from bit 7 or 15.
- Codes 101 and 110 zero-extend.
- Code 011 passes through.

Handshake and timing:
- `start` while busy is ignored; no queueing.
- Ack arriving on the same cycle the counter reaches TIMEOUT: ack wins, and the transaction completes normally.
- Minimum latency, `start` to `done`: 3 cycles with a zero-wait ack (ack in first REQ cycle).
- `dmem_ack` outside REQ is ignored.

Decomposition:
- Shared package `core_pkg`: localparams for the mem size codes (MEM_NONE, MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state encoding. ALU control uses the same code constants.
- One natural sub-module, `lsu_load_align`: combinational lane select plus sign/zero extension, reusable by a future cache.

Test Plan:
- Load word, addr=0x100, dmem_rdata=0xDEADBEEF, zero-wait ack -> be=1111, dmem_addr=0x100, done at cycle 3, rdata=0xDEADBEEF.
- Load byte signed (001), addr=0x103, rdata word 0x80FF_0000 -> be=1000, rdata=0xFFFFFF80; same with code 101 -> rdata=0x00000080.
- Store half, addr=0x202, wdata=0x1234ABCD -> dmem_we=1, be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, done pulse.
- Misaligned load word at addr=0x101, and store half at 0x103 -> err pulse one cycle after start, dmem_req never asserted, rdata unchanged.
- No ack for TIMEOUT=15 cycles -> dmem_req drops, err pulse, busy falls; a subsequent `start` completes normally.
- Assert rst_n low during REQ with a 3-cycle-delayed ack -> dmem_req=0 immediately, busy=0, no done or err; start ignored while busy in a separate run.
